// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: hazard/redirect controls, instruction-memory
// request/response channel, and the fetched-instruction outputs.
// master = fetch_stage side, slave = surrounding core / memory side.
interface fetch_stage_if;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        ValidF;
    logic [31:0] RD;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;

    modport master (
        input  StallF, PCSrcE, PCTargetE, IMemReady, IMemRValid, IMemRData,
        output IMemReq, IMemAddr, ValidF, RD, PCF, PCPlus4F
    );

    modport slave (
        output StallF, PCSrcE, PCTargetE, IMemReady, IMemRValid, IMemRData,
        input  IMemReq, IMemAddr, ValidF, RD, PCF, PCPlus4F
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order requests, queues {instr, pc}.
// Latency: response enqueued one cycle after IMemRValid, visible on RD next cycle.
// Backpressure: StallF holds the head; requests stop when outstanding+buffered hits QDEPTH.
// Ports: CLK, RST (async active-low), bus (fetch_stage_if.master): StallF/PCSrcE/PCTargetE
// controls, IMemReq/IMemAddr/IMemReady request, IMemRValid/IMemRData response,
// ValidF/RD/PCF/PCPlus4F head-of-queue outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] W_QDEPTH = (CW+1)'(QDEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_req_pc;
    logic [31:0]   r_resp_pc;   // PC of the next response that will be kept
    logic [31:0]   r_q_instr [QDEPTH];
    logic [31:0]   r_q_pc    [QDEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_drop_nxt;

    logic          w_valid;
    logic          w_deq;
    logic          w_req;
    logic          w_acc;
    logic          w_resp;
    logic          w_enq;
    logic [CW:0]   w_used;
    logic [31:0]   w_target;
    logic          w_unused_tgt;

    assign w_target     = {bus.PCTargetE[31:2], 2'b00};
    assign w_unused_tgt = ^bus.PCTargetE[1:0];

    assign w_valid = (r_occ != '0);
    assign w_deq   = w_valid & ~bus.StallF & ~bus.PCSrcE;
    // Credit: entries already owed to the queue, minus the slot freed this cycle.
    assign w_used  = (CW+1)'(r_out) + (CW+1)'(r_occ) - (CW+1)'(w_deq);
    assign w_req   = ~bus.PCSrcE & (w_used < W_QDEPTH);
    assign w_acc   = w_req & bus.IMemReady;
    assign w_resp  = bus.IMemRValid;
    // Wrong-path responses still in flight are discarded while draining.
    assign w_enq   = w_resp & ~bus.PCSrcE & (r_state == RUN);

    always_comb begin
        w_drop_nxt  = r_drop;
        w_state_nxt = r_state;
        if (bus.PCSrcE) begin
            w_drop_nxt = r_out - CW'(w_resp);
        end else if (w_resp && (r_state == DRAIN)) begin
            w_drop_nxt = r_drop - CW'(1);
        end
        case (r_state)
            RUN:     if (w_drop_nxt != '0) w_state_nxt = DRAIN;
            DRAIN:   if (w_drop_nxt == '0) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= RUN;
            r_req_pc  <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_out     <= '0;
            r_drop    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            r_out   <= r_out + CW'(w_acc) - CW'(w_resp);
            if (bus.PCSrcE) begin
                r_req_pc  <= w_target;
                r_resp_pc <= w_target;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_occ     <= '0;
            end else begin
                if (w_acc) r_req_pc <= r_req_pc + 32'd4;
                if (w_enq) begin
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
                r_occ <= r_occ + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    // Queue storage needs no reset: r_occ gates every read.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_q_instr[r_wr_ptr] <= bus.IMemRData;
            r_q_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

    assign bus.IMemReq  = w_req;
    assign bus.IMemAddr = r_req_pc;
    assign bus.ValidF   = w_valid;
    assign bus.RD       = w_valid ? r_q_instr[r_rd_ptr] : NOP;
    assign bus.PCF      = w_valid ? r_q_pc[r_rd_ptr] : 32'h0;
    assign bus.PCPlus4F = w_valid ? (r_q_pc[r_rd_ptr] + 32'd4) : 32'h0;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of accepted fetches vs dequeued instructions,
// plus a second instance with a wrapping reset PC.
// Memory model has configurable latency and optional random ready.
module tb_fetch_stage;
    localparam int QD = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    fetch_stage_if bi();
    fetch_stage_if wi();

    fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) u_dut (
        .CLK(CLK), .RST(RST), .bus(bi.master));
    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD)) u_dut_w (
        .CLK(CLK), .RST(RST), .bus(wi.master));

    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t  sb[$];
    mreq_t mq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    lat     = 1;
    int    out_cnt = 0;
    bit    rdy_rand = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        mq.delete();
        out_cnt = 0;
        bi.IMemRValid = 1'b0;
        wi.IMemRValid = 1'b0;
    endtask

    // Main-DUT memory model and scoreboard: sample before the edge, act after it.
    initial begin
        logic s_acc, s_resp, s_deq;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                s_acc  = bi.IMemReq & bi.IMemReady;
                s_resp = bi.IMemRValid;
                s_deq  = bi.ValidF & ~bi.StallF & ~bi.PCSrcE;
                if (!bi.ValidF) begin
                    check("idle_rd_nop", bi.RD, 32'h0000_0013);
                    check("idle_pcf_zero", bi.PCF, 32'h0);
                end
                if (s_deq) begin
                    check("deq_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("pcf", bi.PCF, e.pc);
                        check("rd", bi.RD, e.ins);
                        check("pcplus4", bi.PCPlus4F, e.pc + 32'd4);
                    end
                end
                if (bi.PCSrcE) sb.delete();
                if (s_acc) begin
                    sb.push_back('{bi.IMemAddr, memf(bi.IMemAddr)});
                    mq.push_back('{bi.IMemAddr, cyc + lat});
                end
                if (s_resp && mq.size() != 0) void'(mq.pop_front());
                out_cnt = out_cnt + int'(s_acc) - int'(s_resp);
                check("out_bound", 32'(out_cnt <= QD), 32'd1);
            end
            @(posedge CLK);
            cyc++;
            #1;
            if (RST && mq.size() != 0 && mq[0].due <= cyc) begin
                bi.IMemRValid = 1'b1;
                bi.IMemRData  = memf(mq[0].addr);
            end else begin
                bi.IMemRValid = 1'b0;
                bi.IMemRData  = 32'hDEAD_BEEF;
            end
            bi.IMemReady = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Wrap-instance memory: always ready, one-cycle response.
    initial begin
        logic w_acc_s;
        logic [31:0] w_addr_s;
        forever begin
            @(negedge CLK);
            w_acc_s  = RST & wi.IMemReq & wi.IMemReady;
            w_addr_s = wi.IMemAddr;
            @(posedge CLK);
            #1;
            wi.IMemRValid = w_acc_s & RST;
            wi.IMemRData  = memf(w_addr_s);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bi.StallF = 0; bi.PCSrcE = 0; bi.PCTargetE = '0; bi.IMemReady = 1;
        bi.IMemRValid = 0; bi.IMemRData = '0;
        wi.StallF = 0; wi.PCSrcE = 0; wi.PCTargetE = '0; wi.IMemReady = 1;
        wi.IMemRValid = 0; wi.IMemRData = '0;
        #1;
        check("rst_valid", bi.ValidF, 0);
        check("rst_rd", bi.RD, 32'h0000_0013);
        check("rst_pcplus4", bi.PCPlus4F, 0);
        repeat (3) @(posedge CLK);

        // Release: this cycle is cycle 0.
        @(posedge CLK); #2 RST = 1'b1;
        @(negedge CLK);
        check("c0_req", bi.IMemReq, 1);
        check("c0_addr", bi.IMemAddr, 32'h0);
        check("c0_valid", bi.ValidF, 0);
        check("w_c0_addr", wi.IMemAddr, 32'hFFFF_FFF8);
        @(negedge CLK);
        check("c1_valid", bi.ValidF, 0);
        @(negedge CLK);
        check("c2_valid", bi.ValidF, 1);
        check("c2_pcf", bi.PCF, 32'h0);
        check("c2_pcplus4", bi.PCPlus4F, 32'h4);
        check("c2_rd", bi.RD, memf(32'h0));
        check("w_c2_pcf", wi.PCF, 32'hFFFF_FFF8);
        check("w_c2_rd", wi.RD, memf(32'hFFFF_FFF8));
        @(negedge CLK);
        check("c3_pcf", bi.PCF, 32'h4);
        check("w_c3_pcf", wi.PCF, 32'hFFFF_FFFC);
        check("w_c3_pcplus4", wi.PCPlus4F, 32'h0);
        @(negedge CLK);
        check("c4_pcf", bi.PCF, 32'h8);
        check("w_c4_pcf", wi.PCF, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("stream_valid", bi.ValidF, 1);
        end

        // Five-cycle stall mid-stream: head held, issue stops at full credit.
        @(posedge CLK); #1 bi.StallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_valid", bi.ValidF, 1);
            if (sb.size() != 0) check("stall_hold_pc", bi.PCF, sb[0].pc);
        end
        check("stall_req_off", bi.IMemReq, 0);
        @(posedge CLK); #1 bi.StallF = 1'b0;
        repeat (20) @(negedge CLK);

        // Redirect coinciding with a response while stalled.
        @(posedge CLK); #1;
        bi.StallF = 1'b1; bi.PCSrcE = 1'b1; bi.PCTargetE = 32'h0000_0246;
        @(negedge CLK);
        check("rdN_req", bi.IMemReq, 0);
        @(posedge CLK); #1 bi.PCSrcE = 1'b0; bi.StallF = 1'b0;
        @(negedge CLK);
        check("rdN1_valid", bi.ValidF, 0);
        check("rdN1_addr", bi.IMemAddr, 32'h0000_0244);
        check("rdN1_req", bi.IMemReq, 1);
        @(negedge CLK);
        check("rdN2_valid", bi.ValidF, 0);
        @(negedge CLK);
        check("rdN3_valid", bi.ValidF, 1);
        check("rdN3_pcf", bi.PCF, 32'h0000_0244);
        check("rdN3_rd", bi.RD, memf(32'h0000_0244));
        repeat (5) @(negedge CLK);

        // Asynchronous reset mid-stream.
        @(posedge CLK); #2 RST = 1'b0;
        clear_model();
        #1;
        check("mrst_valid", bi.ValidF, 0);
        check("mrst_rd", bi.RD, 32'h0000_0013);
        check("mrst_pcf", bi.PCF, 32'h0);
        check("mrst_pcplus4", bi.PCPlus4F, 32'h0);
        check("mrst_addr", bi.IMemAddr, 32'h0);
        check("w_mrst_valid", wi.ValidF, 0);
        check("w_mrst_addr", wi.IMemAddr, 32'hFFFF_FFF8);
        lat = 3;
        repeat (2) @(posedge CLK);

        // 3-cycle memory: redirect in cycle 2 with two requests outstanding.
        @(posedge CLK); #2 RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1 bi.PCSrcE = 1'b1; bi.PCTargetE = 32'h0000_0102;
        @(posedge CLK); #1 bi.PCSrcE = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (bi.ValidF) found = 1;
        end
        check("redir_found", 32'(found), 32'd1);
        check("redir_pcf", bi.PCF, 32'h0000_0100);

        // Random ready, stalls and redirects against the scoreboard.
        rdy_rand = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK); #1;
            bi.StallF    = ($urandom_range(0, 3) == 0);
            bi.PCSrcE    = ($urandom_range(0, 29) == 0);
            bi.PCTargetE = $urandom();
        end
        @(posedge CLK); #1;
        rdy_rand = 0; bi.StallF = 0; bi.PCSrcE = 0;
        repeat (20) @(negedge CLK);
        check("end_valid", bi.ValidF, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
